// File: rtl/accum_table.sv
// ---------------------------------------------------------------------------
// accum_table
//
// Banked accumulator table: NUM_COLS independent columns of MAX_OUT_ROWS
// signed entries that all share one write address and one read address.
// Each incoming partial-sum element either overwrites its entry or is added
// to it with signed saturation. A sticky per-column flag records saturation.
// A clear sequencer walks the rows one per cycle to zero the whole table.
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   asynchronous, active-low reset
//   wrEn       in   write/accumulate request (dropped while busy)
//   wrAccum    in   1 = add to stored value, 0 = overwrite
//   wrMask     in   [NUM_COLS] per-column write enable
//   wrAddr     in   write row
//   wrData     in   [NUM_COLS*DATA_WIDTH] signed elements, column c at
//                   bits [c*DATA_WIDTH +: DATA_WIDTH]
//   rdEn       in   read request (always served, also while busy)
//   rdAddr     in   read row
//   rdData     out  [NUM_COLS*ACC_WIDTH] registered read data, same packing
//   rdValid    out  rdData carries a fresh read result this cycle
//   clrStart   in   start whole-table clear (ignored while busy)
//   busy       out  clear in progress
//   ovf        out  [NUM_COLS] sticky saturation flags
//   dbg_state  out  sequencer state (0 = idle, 1 = clearing)
//
// Handshake: there is no back-pressure on either port. A write is taken on
// any rising edge where wrEn=1, busy=0 and clrStart=0. A read is taken on
// any rising edge where rdEn=1; rdValid is high for exactly the following
// cycle and rdData holds its last value whenever rdValid is low.
// ---------------------------------------------------------------------------
module accum_table #(
  parameter int DATA_WIDTH   = 8,
  parameter int ACC_WIDTH    = 16,
  parameter int MAX_OUT_ROWS = 16,
  parameter int NUM_COLS     = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wrEn,
  input  logic                             wrAccum,
  input  logic [NUM_COLS-1:0]              wrMask,
  input  logic [$clog2(MAX_OUT_ROWS)-1:0]  wrAddr,
  input  logic [NUM_COLS*DATA_WIDTH-1:0]   wrData,
  input  logic                             rdEn,
  input  logic [$clog2(MAX_OUT_ROWS)-1:0]  rdAddr,
  output logic [NUM_COLS*ACC_WIDTH-1:0]    rdData,
  output logic                             rdValid,
  input  logic                             clrStart,
  output logic                             busy,
  output logic [NUM_COLS-1:0]              ovf,
  output logic [0:0]                       dbg_state
);

  localparam int AW = $clog2(MAX_OUT_ROWS);
  // Sums are formed one bit wider than an entry so overflow is visible as a
  // disagreement between the two top bits.
  localparam int SW = ACC_WIDTH + 1;

  localparam logic [AW:0]          ROWS_EXT = (AW + 1)'(MAX_OUT_ROWS);
  localparam logic [AW-1:0]        LAST_ROW = AW'(MAX_OUT_ROWS - 1);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // ------------------------------------------------------------------------
  // Sequencer state
  // ------------------------------------------------------------------------
  logic [0:0]    state;
  logic [AW-1:0] clr_cnt;
  logic          clearing;

  assign clearing  = (state == ST_CLEAR);
  assign busy      = clearing;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      clr_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (clrStart) begin
        state   <= ST_CLEAR;
        clr_cnt <= '0;
      end
    end else begin
      // One row is zeroed per cycle; the last row returns us to idle.
      if (clr_cnt == LAST_ROW) begin
        state   <= ST_IDLE;
        clr_cnt <= '0;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Address qualification
  // ------------------------------------------------------------------------
  // Rows beyond MAX_OUT_ROWS only exist when the row count is not a power
  // of two. Out-of-range addresses are folded to row 0 for the array index
  // and then masked, so nothing ever indexes past the table.
  logic          wr_ok;
  logic          rd_ok;
  logic [AW-1:0] wr_row;
  logic [AW-1:0] rd_row;
  logic          wr_fire;

  assign wr_ok  = ({1'b0, wrAddr} < ROWS_EXT);
  assign rd_ok  = ({1'b0, rdAddr} < ROWS_EXT);
  assign wr_row = wr_ok ? wrAddr : '0;
  assign rd_row = rd_ok ? rdAddr : '0;

  // clrStart wins over a same-cycle write, and nothing is written while a
  // clear is walking the table.
  assign wr_fire = wrEn && !clearing && !clrStart && wr_ok;

  // ------------------------------------------------------------------------
  // Storage and per-column datapath
  // ------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0]            mem     [NUM_COLS][MAX_OUT_ROWS];
  logic [ACC_WIDTH-1:0]            new_val [NUM_COLS];
  logic [NUM_COLS-1:0]             sat_vec;
  logic [NUM_COLS*ACC_WIDTH-1:0]   rd_word;

  for (genvar gc = 0; gc < NUM_COLS; gc++) begin : g_col
    logic [DATA_WIDTH-1:0] elem;
    logic [SW-1:0]         ext;
    logic [SW-1:0]         cur;
    logic [SW-1:0]         sum;
    logic                  sum_ovr;
    logic [ACC_WIDTH-1:0]  acc_val;

    assign elem = wrData[gc*DATA_WIDTH +: DATA_WIDTH];
    assign ext  = {{(SW-DATA_WIDTH){elem[DATA_WIDTH-1]}}, elem};
    assign cur  = {mem[gc][wr_row][ACC_WIDTH-1], mem[gc][wr_row]};
    assign sum  = cur + ext;

    // Both operands fit in ACC_WIDTH bits, so the true sum fits in SW bits;
    // the result overflowed the entry exactly when the top two bits differ.
    assign sum_ovr = sum[SW-1] ^ sum[SW-2];
    assign acc_val = sum_ovr ? (sum[SW-1] ? ACC_MIN : ACC_MAX)
                             : sum[ACC_WIDTH-1:0];

    // An overwrite cannot saturate because ACC_WIDTH >= DATA_WIDTH.
    assign new_val[gc] = wrAccum ? acc_val : ext[ACC_WIDTH-1:0];
    assign sat_vec[gc] = wrAccum && sum_ovr;

    assign rd_word[gc*ACC_WIDTH +: ACC_WIDTH] = rd_ok ? mem[gc][rd_row] : '0;

    // One register per entry so that every entry has its own asynchronous
    // reset and its own clear/write select.
    for (genvar gr = 0; gr < MAX_OUT_ROWS; gr++) begin : g_row
      logic [ACC_WIDTH-1:0] q;
      logic                 clr_hit;
      logic                 wr_hit;

      assign clr_hit = clearing && (clr_cnt == AW'(gr));
      assign wr_hit  = wr_fire && wrMask[gc] && (wr_row == AW'(gr));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          q <= '0;
        end else if (clr_hit) begin
          q <= '0;
        end else if (wr_hit) begin
          q <= new_val[gc];
        end
      end

      assign mem[gc][gr] = q;
    end
  end

  // ------------------------------------------------------------------------
  // Sticky saturation flags
  // ------------------------------------------------------------------------
  // Flags are wiped on the first clear cycle. No write can be taken while
  // clearing, so nothing can set a flag again before the clear completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= '0;
    end else if (clearing && (clr_cnt == '0)) begin
      ovf <= '0;
    end else if (wr_fire) begin
      ovf <= ovf | (wrMask & sat_vec);
    end
  end

  // ------------------------------------------------------------------------
  // Read port
  // ------------------------------------------------------------------------
  // The read samples the table before this edge's write/clear lands, which
  // gives read-before-write behaviour on an address collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdData  <= '0;
      rdValid <= 1'b0;
    end else begin
      rdValid <= rdEn;
      if (rdEn) begin
        rdData <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_accum_table.sv
module tb_accum_table;

  localparam int DW   = 8;
  localparam int ACCW = 16;
  localparam int ROWS = 16;
  localparam int COLS = 4;
  localparam int ADRW = 4;
  localparam int SAT_HI = 32767;
  localparam int SAT_LO = -32768;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic                 wrEn = 1'b0;
  logic                 wrAccum = 1'b0;
  logic [COLS-1:0]      wrMask = '0;
  logic [ADRW-1:0]      wrAddr = '0;
  logic [COLS*DW-1:0]   wrData = '0;
  logic                 rdEn = 1'b0;
  logic [ADRW-1:0]      rdAddr = '0;
  logic [COLS*ACCW-1:0] rdData;
  logic                 rdValid;
  logic                 clrStart = 1'b0;
  logic                 busy;
  logic [COLS-1:0]      ovf;
  logic [0:0]           dbg_state;

  accum_table #(
    .DATA_WIDTH  (DW),
    .ACC_WIDTH   (ACCW),
    .MAX_OUT_ROWS(ROWS),
    .NUM_COLS    (COLS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wrEn     (wrEn),
    .wrAccum  (wrAccum),
    .wrMask   (wrMask),
    .wrAddr   (wrAddr),
    .wrData   (wrData),
    .rdEn     (rdEn),
    .rdAddr   (rdAddr),
    .rdData   (rdData),
    .rdValid  (rdValid),
    .clrStart (clrStart),
    .busy     (busy),
    .ovf      (ovf),
    .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  // Table contents as plain integers; clear progress as "next row to zero",
  // -1 when no clear is running.
  int              model [COLS][ROWS];
  logic [COLS-1:0] m_ovf;
  int              clr_pos;
  logic [COLS*ACCW-1:0] exp_rd;
  logic            exp_valid;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [COLS*ACCW-1:0] pack_row(input int a);
    logic [COLS*ACCW-1:0] r;
    r = '0;
    for (int c = 0; c < COLS; c++) r[c*ACCW +: ACCW] = 16'(model[c][a]);
    return r;
  endfunction

  function automatic logic [COLS*DW-1:0] mk_data(input int d0, input int d1, input int d2, input int d3);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(d0); b1 = 8'(d1); b2 = 8'(d2); b3 = 8'(d3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) model[c][r] = 0;
    m_ovf     = '0;
    clr_pos   = -1;
    exp_rd    = '0;
    exp_valid = 1'b0;
  endtask

  // Apply what one rising edge does, given the inputs held across it.
  task automatic model_edge();
    int d, v;
    if (rdEn) begin
      exp_valid = 1'b1;
      exp_rd    = (int'(rdAddr) < ROWS) ? pack_row(int'(rdAddr)) : '0;
    end else begin
      exp_valid = 1'b0;
    end
    if (clr_pos >= 0) begin
      for (int c = 0; c < COLS; c++) model[c][clr_pos] = 0;
      if (clr_pos == 0) m_ovf = '0;
      clr_pos++;
      if (clr_pos == ROWS) clr_pos = -1;
    end else if (clrStart) begin
      clr_pos = 0;
    end else if (wrEn && int'(wrAddr) < ROWS) begin
      for (int c = 0; c < COLS; c++) begin
        if (wrMask[c]) begin
          d = int'($signed(wrData[c*DW +: DW]));
          if (wrAccum) begin
            v = model[c][wrAddr] + d;
            if (v > SAT_HI) begin v = SAT_HI; m_ovf[c] = 1'b1; end
            if (v < SAT_LO) begin v = SAT_LO; m_ovf[c] = 1'b1; end
          end else begin
            v = d;
          end
          model[c][wrAddr] = v;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("rdValid", rdValid, exp_valid);
    check("rdData", rdData, exp_rd);
    check("busy", busy, (clr_pos >= 0));
    check("dbg_state", dbg_state, (clr_pos >= 0));
    check("ovf", ovf, m_ovf);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
    model_edge();
    check_outputs();
  endtask

  task automatic do_write(input int addr, input logic [COLS-1:0] mask, input logic acc,
                          input logic [COLS*DW-1:0] data);
    wrEn = 1'b1; wrAddr = ADRW'(addr); wrMask = mask; wrAccum = acc; wrData = data;
    cycle();
    wrEn = 1'b0;
  endtask

  task automatic do_read(input int addr);
    rdEn = 1'b1; rdAddr = ADRW'(addr);
    cycle();
    rdEn = 1'b0;
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int busy_cnt;
    int r;
    logic [COLS*ACCW-1:0] all_zero;
    all_zero = '0;

    model_reset();

    // reset state, checked while reset is still held and before any edge
    #1;
    check("reset_rdData", rdData, all_zero);
    check("reset_rdValid", rdValid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_ovf", ovf, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // overwrite then two accumulates, read back
    do_write(3, 4'hF, 1'b0, mk_data(4, -3, 2, 1));
    do_write(3, 4'hF, 1'b1, mk_data(1, 1, 1, 1));
    do_write(3, 4'hF, 1'b1, mk_data(1, 1, 1, 1));
    do_read(3);
    check("row3_rdValid", rdValid, 1'b1);
    check("row3_value", rdData, {16'd3, 16'd4, 16'hFFFF, 16'd6});
    cycle();
    check("row3_rdValid_drop", rdValid, 1'b0);
    check("row3_held", rdData, {16'd3, 16'd4, 16'hFFFF, 16'd6});

    // saturation in column 0 of row 0
    for (int i = 0; i < 300; i++) do_write(0, 4'b0001, 1'b1, mk_data(127, 0, 0, 0));
    do_read(0);
    check("sat_value", rdData[15:0], 16'h7FFF);
    check("sat_ovf", ovf, 4'b0001);
    do_write(0, 4'b0001, 1'b1, mk_data(-128, 0, 0, 0));
    do_read(0);
    check("desat_value", rdData[15:0], 16'h7F7F);

    // masked overwrite
    do_write(5, 4'b0101, 1'b0, mk_data(9, 9, 9, 9));
    do_read(5);
    check("mask_row5", rdData, {16'd0, 16'd9, 16'd0, 16'd9});

    // read-before-write collision
    do_write(7, 4'hF, 1'b0, mk_data(10, 10, 10, 10));
    rdEn = 1'b1; rdAddr = 4'd7;
    do_write(7, 4'hF, 1'b1, mk_data(5, 5, 5, 5));
    rdEn = 1'b0;
    check("rbw_old", rdData[15:0], 16'd10);
    do_read(7);
    check("rbw_new", rdData[15:0], 16'd15);

    // fill, clear with simultaneous write, mid-clear clrStart
    for (int a = 0; a < ROWS; a++)
      do_write(a, 4'hF, 1'b0, mk_data($urandom_range(1, 100), $urandom_range(1, 100),
                                      $urandom_range(1, 100), $urandom_range(1, 100)));
    check("pre_clear_ovf", ovf, 4'b0001);
    clrStart = 1'b1; wrEn = 1'b1; wrAddr = 4'd2; wrMask = 4'hF; wrAccum = 1'b0;
    wrData = mk_data(55, 55, 55, 55);
    cycle();
    clrStart = 1'b0; wrEn = 1'b0;
    busy_cnt = busy ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin clrStart = 1'b1; wrEn = 1'b1; end
      cycle();
      clrStart = 1'b0; wrEn = 1'b0;
      if (busy) busy_cnt++;
    end
    check("clear_busy_cycles", busy_cnt, 16);
    check("clear_ovf", ovf, 4'b0000);
    for (int a = 0; a < ROWS; a++) begin
      do_read(a);
      check("clear_row_zero", rdData, all_zero);
    end

    // async reset in the middle of a clear
    for (int a = 0; a < ROWS; a++)
      do_write(a, 4'hF, 1'b0, mk_data($urandom_range(1, 100), 3, 4, 5));
    clrStart = 1'b1;
    cycle();
    clrStart = 1'b0;
    rdEn = 1'b1; rdAddr = 4'd15;
    for (int i = 0; i < 6; i++) cycle();
    rdEn = 1'b0;
    check("midclear_busy", busy, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check("arst_rdData", rdData, all_zero);
    check("arst_rdValid", rdValid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_ovf", ovf, 4'b0000);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    for (int a = 0; a < ROWS; a++) begin
      do_read(a);
      check("arst_row_zero", rdData, all_zero);
    end

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      wrEn     = 1'($urandom_range(0, 1));
      wrAccum  = 1'($urandom_range(0, 1));
      wrMask   = 4'($urandom_range(0, 15));
      wrAddr   = 4'($urandom_range(0, 15));
      wrData   = 32'($urandom);
      rdEn     = 1'($urandom_range(0, 1));
      rdAddr   = 4'($urandom_range(0, 15));
      r        = $urandom_range(0, 99);
      clrStart = (r < 2);
      cycle();
    end
    wrEn = 1'b0; rdEn = 1'b0; clrStart = 1'b0;
    repeat (ROWS + 2) cycle();
    for (int a = 0; a < ROWS; a++) do_read(a);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
